// File: rtl/gol_pkg.sv
// gol_pkg: shared constants and types for the Game-of-Life loader and engine.
//   - board geometry defaults (BIT_WIDTH, BIT_HEIGHT, BOARD_CELLS)
//   - loader state enum (CHECK state exists only with GOL_LOADER_CHECKSUM_EN)
//   - preset select encodings and the four preset board constants
// Board bit index = row*8 + col; col 0 is the leftmost cell.
package gol_pkg;

  localparam int BIT_WIDTH   = 3;
  localparam int BIT_HEIGHT  = 3;
  localparam int BOARD_CELLS = 1 << (BIT_WIDTH + BIT_HEIGHT);

`ifdef GOL_LOADER_CHECKSUM_EN
  typedef enum logic [1:0] {ST_IDLE, ST_RECV, ST_HOLD, ST_CHECK} ld_state_e;
`else
  typedef enum logic [1:0] {ST_IDLE, ST_RECV, ST_HOLD} ld_state_e;
`endif

  localparam logic [1:0] PRESET_UW      = 2'd0;
  localparam logic [1:0] PRESET_GLIDER  = 2'd1;
  localparam logic [1:0] PRESET_BLINKER = 2'd2;
  localparam logic [1:0] PRESET_CLEAR   = 2'd3;

  // Row 7 is the most significant byte.
  localparam logic [BOARD_CELLS-1:0] PRESET_UW_BITS      = 64'h50A8_8888_0609_0909;
  localparam logic [BOARD_CELLS-1:0] PRESET_GLIDER_BITS  = 64'h0000_0000_0007_0402;
  localparam logic [BOARD_CELLS-1:0] PRESET_BLINKER_BITS = 64'h0000_0000_3800_0000;
  localparam logic [BOARD_CELLS-1:0] PRESET_CLEAR_BITS   = '0;

endpackage

// File: rtl/gol_preset_rom.sv
// gol_preset_rom: combinational preset pattern lookup.
//   preset_sel in  2           : PRESET_* select
//   pattern    out BOARD_CELLS : board image, bit index = row*8+col
module gol_preset_rom
  import gol_pkg::*;
(
  input  logic [1:0]             preset_sel,
  output logic [BOARD_CELLS-1:0] pattern
);

  always_comb begin
    pattern = PRESET_CLEAR_BITS;
    case (preset_sel)
      PRESET_UW:      pattern = PRESET_UW_BITS;
      PRESET_GLIDER:  pattern = PRESET_GLIDER_BITS;
      PRESET_BLINKER: pattern = PRESET_BLINKER_BITS;
      default:        pattern = PRESET_CLEAR_BITS;
    endcase
  end

endmodule

// File: rtl/gol_pattern_loader.sv
// gol_pattern_loader: builds a seed board from a row-byte stream or a preset
// ROM and holds it on a valid/ready output until the engine takes it.
// Ports:
//   clk, rst_n (async, active-low)
//   load_start   : pulse, start stream load (IDLE only, wins over preset_load)
//   preset_load  : pulse, commit ROM[preset_sel] (IDLE only)
//   in_data/in_valid/in_ready : row byte stream, byte k -> row k, bit j -> col j
//   board/board_valid/board_ready : committed board handshake
//   busy : state != IDLE
//   err  : sticky, set on inter-byte timeout (or checksum mismatch), cleared
//          by the next load_start
// Config macro: GOL_LOADER_CHECKSUM_EN adds a 9th XOR-checksum byte and a
// one-cycle CHECK state before commit.
// Presets are 8x8 images; in_data is one 8-cell row.
module gol_pattern_loader #(
  parameter int BIT_WIDTH  = gol_pkg::BIT_WIDTH,
  parameter int BIT_HEIGHT = gol_pkg::BIT_HEIGHT,
  parameter int TIMEOUT_W  = 20
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 load_start,
  input  logic                                 preset_load,
  input  logic [1:0]                           preset_sel,
  input  logic [7:0]                           in_data,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  output logic [2**(BIT_WIDTH+BIT_HEIGHT)-1:0] board,
  output logic                                 board_valid,
  input  logic                                 board_ready,
  output logic                                 busy,
  output logic                                 err
);
  import gol_pkg::*;

  localparam int CELLS = 2**(BIT_WIDTH+BIT_HEIGHT);
  localparam int ROW_W = 2**BIT_WIDTH;
  localparam int ROWS  = 2**BIT_HEIGHT;
`ifdef GOL_LOADER_CHECKSUM_EN
  localparam int CNT_W = BIT_HEIGHT + 1;   // one extra count for the checksum byte
`else
  localparam int CNT_W = BIT_HEIGHT;       // wraps to 0 on the last row
`endif

  ld_state_e              state, state_nx;
  logic [CNT_W-1:0]       cnt;
  logic [TIMEOUT_W-1:0]   tmo;
  logic [CELLS-1:0]       shadow, shadow_wr;
  logic [BOARD_CELLS-1:0] rom_pat;
  logic                   last_byte;

  gol_preset_rom u_rom (.preset_sel(preset_sel), .pattern(rom_pat));

  assign in_ready = (state == ST_RECV);
  assign busy     = (state != ST_IDLE);

`ifdef GOL_LOADER_CHECKSUM_EN
  logic [ROW_W-1:0] chk;
  logic [ROW_W-1:0] xsum;
  logic             chk_ok;
  assign last_byte = (cnt == CNT_W'(ROWS));
  always_comb begin
    xsum = '0;
    for (int r = 0; r < ROWS; r++) xsum ^= shadow[r*ROW_W +: ROW_W];
  end
  assign chk_ok = (xsum == chk);
`else
  assign last_byte = (cnt == CNT_W'(ROWS-1));
`endif

  // Shadow with the incoming byte merged in, so the last row commits in the
  // same cycle it is accepted.
  always_comb begin
    shadow_wr = shadow;
    shadow_wr[cnt[BIT_HEIGHT-1:0]*ROW_W +: ROW_W] = in_data;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: begin
        if (load_start)       state_nx = ST_RECV;
        else if (preset_load) state_nx = ST_HOLD;
      end
      ST_RECV: begin
        if (in_valid) begin
`ifdef GOL_LOADER_CHECKSUM_EN
          if (last_byte) state_nx = ST_CHECK;
`else
          if (last_byte) state_nx = ST_HOLD;
`endif
        end else if (tmo == '1) begin
          state_nx = ST_IDLE;
        end
      end
`ifdef GOL_LOADER_CHECKSUM_EN
      ST_CHECK: state_nx = chk_ok ? ST_HOLD : ST_IDLE;
`endif
      ST_HOLD:  if (board_ready) state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      board       <= '0;
      board_valid <= 1'b0;
      err         <= 1'b0;
      cnt         <= '0;
      tmo         <= '0;
      shadow      <= '0;
`ifdef GOL_LOADER_CHECKSUM_EN
      chk         <= '0;
`endif
    end else begin
      state <= state_nx;
      case (state)
        ST_IDLE: begin
          if (load_start) begin
            cnt    <= '0;
            tmo    <= '0;
            shadow <= '0;
            err    <= 1'b0;
          end else if (preset_load) begin
            board       <= CELLS'(rom_pat);
            board_valid <= 1'b1;
          end
        end
        ST_RECV: begin
          if (in_valid) begin
            tmo <= '0;
            cnt <= cnt + 1'b1;
`ifdef GOL_LOADER_CHECKSUM_EN
            if (last_byte) chk    <= in_data;
            else           shadow <= shadow_wr;
`else
            shadow <= shadow_wr;
            if (last_byte) begin
              board       <= shadow_wr;
              board_valid <= 1'b1;
            end
`endif
          end else if (tmo == '1) begin
            err <= 1'b1;
          end else begin
            tmo <= tmo + 1'b1;
          end
        end
`ifdef GOL_LOADER_CHECKSUM_EN
        ST_CHECK: begin
          if (chk_ok) begin
            board       <= shadow;
            board_valid <= 1'b1;
          end else begin
            err <= 1'b1;
          end
        end
`endif
        ST_HOLD: if (board_ready) board_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gol_pattern_loader.sv
module tb_gol_pattern_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load_start = 1'b0;
  logic        preset_load = 1'b0;
  logic [1:0]  preset_sel = 2'd0;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] board;
  logic        board_valid;
  logic        board_ready = 1'b0;
  logic        busy;
  logic        err;

  int checks = 0;
  int failures = 0;
  logic [63:0] model_board = '0;   // last committed board, per the rules

  gol_pattern_loader #(.BIT_WIDTH(3), .BIT_HEIGHT(3), .TIMEOUT_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .load_start(load_start), .preset_load(preset_load),
    .preset_sel(preset_sel), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .board(board), .board_valid(board_valid), .board_ready(board_ready),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk); #1;
  endtask

  // Reference: row r byte, bit c -> cell r*8+c.
  function automatic logic [63:0] rows_to_board(input logic [7:0] rows [8]);
    logic [63:0] b = '0;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        b[r*8 + c] = rows[r][c];
    return b;
  endfunction

  function automatic logic [63:0] preset_model(input int sel);
    int uw [17] = '{0,3,8,11,16,19,25,26,35,39,43,47,51,53,55,60,62};
    int gl [5]  = '{1,10,16,17,18};
    int bl [3]  = '{27,28,29};
    logic [63:0] b = '0;
    if (sel == 0) foreach (uw[i]) b[uw[i]] = 1'b1;
    if (sel == 1) foreach (gl[i]) b[gl[i]] = 1'b1;
    if (sel == 2) foreach (bl[i]) b[bl[i]] = 1'b1;
    return b;
  endfunction

  // Offer one byte after 'gap' idle cycles; returns once it is accepted.
  task automatic send_byte(input logic [7:0] d, input int gap);
    bit done = 0;
    in_valid = 1'b0;
    repeat (gap) tick;
    in_data  = d;
    in_valid = 1'b1;
    for (int i = 0; i < 10 && !done; i++) begin
      if (in_ready) done = 1;
      tick;
    end
    in_valid = 1'b0;
    if (!done) begin
      checks++; failures++;
      $display("FAIL send_byte in_ready never seen for byte %h", d);
    end
  endtask

  // Rows 0..7 (plus checksum byte and CHECK cycle when enabled).
  task automatic send_rows(input logic [7:0] rows [8], input int max_gap);
    logic [7:0] x = '0;
    for (int r = 0; r < 8; r++) begin
      send_byte(rows[r], int'($urandom_range(0, max_gap)));
      x ^= rows[r];
    end
`ifdef GOL_LOADER_CHECKSUM_EN
    send_byte(x, 0);
    tick;
`endif
  endtask

  task automatic pulse_start;
    load_start = 1'b1; tick; load_start = 1'b0;
  endtask

  task automatic release_board;
    board_ready = 1'b1; tick; board_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #12;
    checks++;
    if ({board, board_valid, in_ready, busy, err} !== 68'h0) begin
      failures++;
      $display("FAIL reset_outputs got=%h exp=0", {board, board_valid, in_ready, busy, err});
    end
    @(negedge clk); rst_n = 1'b1;
    tick;
    checks++;
    if (busy !== 1'b0 || board_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_release busy=%b valid=%b exp 0 0", busy, board_valid);
    end
  endtask

  task automatic test_presets;
    int order [5];
    order = '{0, 1, 2, 3, int'($urandom_range(0, 3))};
    foreach (order[k]) begin
      logic [63:0] exp = preset_model(order[k]);
      preset_sel = 2'(order[k]); preset_load = 1'b1; tick; preset_load = 1'b0;
      preset_sel = 2'($urandom);
      checks++;
      if (board_valid !== 1'b1 || board !== exp || busy !== 1'b1) begin
        failures++;
        $display("FAIL preset%0d got valid=%b busy=%b board=%h exp 1 1 %h",
                 order[k], board_valid, busy, board, exp);
      end
      if (k == 0) begin
        bit stable = 1;
        repeat (100) begin
          tick;
          if (board !== exp || board_valid !== 1'b1) stable = 0;
        end
        checks++;
        if (!stable) begin
          failures++;
          $display("FAIL preset_hold board=%h valid=%b exp %h 1", board, board_valid, exp);
        end
      end
      release_board;
      model_board = exp;
      checks++;
      if (board_valid !== 1'b0 || busy !== 1'b0 || board !== exp) begin
        failures++;
        $display("FAIL preset_release valid=%b busy=%b board=%h exp 0 0 %h",
                 board_valid, busy, board, exp);
      end
    end
  endtask

  task automatic test_diagonal;
    logic [7:0] rows [8];
    logic [63:0] exp;
    for (int r = 0; r < 8; r++) rows[r] = 8'(1 << r);
    exp = rows_to_board(rows);
    pulse_start;
    for (int r = 0; r < 7; r++) send_byte(rows[r], int'($urandom_range(0, 3)));
    checks++;
    if (board !== model_board || board_valid !== 1'b0) begin
      failures++;
      $display("FAIL diag_early_commit board=%h valid=%b exp %h 0", board, board_valid, model_board);
    end
`ifdef GOL_LOADER_CHECKSUM_EN
    send_byte(rows[7], 1);
    send_byte(8'hFF, 0);
    tick;
`else
    send_byte(rows[7], 2);
`endif
    model_board = exp;
    checks++;
    if (board !== exp || board_valid !== 1'b1 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL diag_commit board=%h valid=%b ready=%b exp %h 1 0",
               board, board_valid, in_ready, exp);
    end
    // Pulses while holding are ignored.
    preset_sel = 2'd3; preset_load = 1'b1; tick; preset_load = 1'b0;
    load_start = 1'b1; tick; load_start = 1'b0;
    checks++;
    if (board !== exp || board_valid !== 1'b1 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL hold_ignores_pulses board=%h valid=%b ready=%b exp %h 1 0",
               board, board_valid, in_ready, exp);
    end
    release_board;
    // board_ready with nothing valid does nothing.
    board_ready = 1'b1; tick; tick; board_ready = 1'b0;
    checks++;
    if (board !== exp || board_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL idle_ready board=%h valid=%b busy=%b exp %h 0 0", board, board_valid, busy, exp);
    end
  endtask

  task automatic test_random_loads;
    logic [7:0] rows [8];
    for (int n = 0; n < 4; n++) begin
      for (int r = 0; r < 8; r++) rows[r] = 8'($urandom);
      pulse_start;
      send_rows(rows, 3);
      model_board = rows_to_board(rows);
      checks++;
      if (board !== model_board || board_valid !== 1'b1) begin
        failures++;
        $display("FAIL random_load%0d board=%h valid=%b exp %h 1", n, board, board_valid, model_board);
      end
      release_board;
    end
  endtask

  task automatic test_timeout;
    logic [7:0] rows [8];
    int waited = 0;
    pulse_start;
    for (int r = 0; r < 3; r++) send_byte(8'($urandom), int'($urandom_range(0, 3)));
    repeat (40) tick;
    checks++;
    if (busy !== 1'b1 || err !== 1'b0) begin
      failures++;
      $display("FAIL timeout_early busy=%b err=%b exp 1 0", busy, err);
    end
    while (busy === 1'b1 && waited < 60) begin tick; waited++; end
    checks++;
    if (busy !== 1'b0 || err !== 1'b1 || board !== model_board || board_valid !== 1'b0) begin
      failures++;
      $display("FAIL timeout busy=%b err=%b valid=%b board=%h exp 0 1 0 %h",
               busy, err, board_valid, board, model_board);
    end
    repeat (3) tick;
    checks++;
    if (err !== 1'b1) begin
      failures++;
      $display("FAIL err_sticky got=%b exp=1", err);
    end
    pulse_start;
    checks++;
    if (err !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL err_clear err=%b ready=%b exp 0 1", err, in_ready);
    end
    for (int r = 0; r < 8; r++) rows[r] = 8'($urandom);
    send_rows(rows, 1);
    model_board = rows_to_board(rows);
    checks++;
    if (board !== model_board || board_valid !== 1'b1 || err !== 1'b0) begin
      failures++;
      $display("FAIL after_timeout_load board=%h valid=%b err=%b exp %h 1 0",
               board, board_valid, err, model_board);
    end
    release_board;
  endtask

  task automatic test_reset_midload;
    logic [7:0] rows [8];
    pulse_start;
    for (int r = 0; r < 5; r++) send_byte(8'($urandom), 0);
    rst_n = 1'b0;
    #2;   // no clock edge in between: reset must act immediately
    checks++;
    if ({board, board_valid, in_ready, busy, err} !== 68'h0) begin
      failures++;
      $display("FAIL midload_reset got=%h exp=0", {board, board_valid, in_ready, busy, err});
    end
    model_board = '0;
    @(negedge clk); rst_n = 1'b1; tick;
    for (int r = 0; r < 8; r++) rows[r] = 8'($urandom);
    pulse_start;
    send_rows(rows, 2);
    model_board = rows_to_board(rows);
    checks++;
    if (board !== model_board || board_valid !== 1'b1) begin
      failures++;
      $display("FAIL post_reset_load board=%h valid=%b exp %h 1", board, board_valid, model_board);
    end
    release_board;
  endtask

  task automatic test_both_pulses;
    logic [7:0] rows [8];
    preset_sel = 2'd1; preset_load = 1'b1; load_start = 1'b1;
    tick;
    preset_load = 1'b0; load_start = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || board_valid !== 1'b0 || board !== model_board) begin
      failures++;
      $display("FAIL both_pulses ready=%b valid=%b board=%h exp 1 0 %h",
               in_ready, board_valid, board, model_board);
    end
    for (int r = 0; r < 8; r++) rows[r] = 8'($urandom);
    send_rows(rows, 0);
    model_board = rows_to_board(rows);
    checks++;
    if (board !== model_board || board_valid !== 1'b1) begin
      failures++;
      $display("FAIL both_pulses_load board=%h valid=%b exp %h 1", board, board_valid, model_board);
    end
    release_board;
  endtask

`ifdef GOL_LOADER_CHECKSUM_EN
  task automatic test_checksum;
    pulse_start;
    for (int r = 0; r < 8; r++) send_byte(8'hFF, 0);
    send_byte(8'h00, 0);
    checks++;
    if (board_valid !== 1'b0) begin
      failures++;
      $display("FAIL chk_latency valid=%b exp 0", board_valid);
    end
    tick;
    model_board = '1;
    checks++;
    if (board !== model_board || board_valid !== 1'b1 || err !== 1'b0) begin
      failures++;
      $display("FAIL chk_good board=%h valid=%b err=%b exp %h 1 0", board, board_valid, err, model_board);
    end
    release_board;
    pulse_start;
    for (int r = 0; r < 8; r++) send_byte(8'h5A, 0);
    send_byte(8'h01, 0);
    tick;
    checks++;
    if (err !== 1'b1 || board_valid !== 1'b0 || busy !== 1'b0 || board !== model_board) begin
      failures++;
      $display("FAIL chk_bad err=%b valid=%b busy=%b board=%h exp 1 0 0 %h",
               err, board_valid, busy, board, model_board);
    end
  endtask
`endif

  initial begin
    test_reset;
    test_presets;
    test_diagonal;
    test_random_loads;
    test_timeout;
    test_reset_midload;
    test_both_pulses;
`ifdef GOL_LOADER_CHECKSUM_EN
    test_checksum;
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
